// File: rtl/fixed_multiplier_pipe.sv
// ----------------------------------------------------------------------------
// fixed_multiplier_pipe : 3-stage sign-magnitude fixed-point multiplier
// Rev 1.0 - initial release
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module fixed_multiplier_pipe #(
  parameter int N     = 16,
  parameter int Q     = 12,
  parameter int ROUND = 1,
  parameter int SAT   = 1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [N-1:0] i_multiplicand,
  input  logic [N-1:0] i_multiplier,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [N-1:0] o_result,
  output logic         o_ovr,
  input  logic         i_clr_ovr,
  output logic         o_ovr_sticky
);

  // Width of the shifted product plus one bit to keep the rounding carry.
  localparam int MW = 2*N - 1 - Q;

  logic           w_en;
  logic           r_s1_valid;
  logic           r_s1_sign;
  logic [N-2:0]   r_s1_a;
  logic [N-2:0]   r_s1_b;
  logic           r_s2_valid;
  logic           r_s2_sign;
  logic [2*N-3:0] r_s2_prod;
  logic           r_s3_valid;
  logic [N-1:0]   r_s3_result;
  logic           r_s3_ovr;
  logic           r_sticky;

  logic           w_rbit;
  logic [MW-1:0]  w_m;
  logic           w_ovr;
  logic [N-2:0]   w_mag;
  logic           w_sign;

  // Whole pipe advances together, bubbles included; stall only on a held output.
  assign w_en    = ~r_s3_valid | i_ready;
  assign o_ready = w_en;

  assign w_rbit = (ROUND != 0) ? r_s2_prod[Q-1] : 1'b0;
  assign w_m    = {1'b0, r_s2_prod[2*N-3:Q]} + {{(MW-1){1'b0}}, w_rbit};
  assign w_ovr  = |w_m[MW-1:N-1];
  assign w_mag  = (w_ovr && (SAT != 0)) ? {(N-1){1'b1}} : w_m[N-2:0];
  // No negative zero: a zero magnitude always leaves with a positive sign.
  assign w_sign = r_s2_sign & (|w_mag);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_sign   <= 1'b0;
      r_s1_a      <= '0;
      r_s1_b      <= '0;
      r_s2_valid  <= 1'b0;
      r_s2_sign   <= 1'b0;
      r_s2_prod   <= '0;
      r_s3_valid  <= 1'b0;
      r_s3_result <= '0;
      r_s3_ovr    <= 1'b0;
    end else if (w_en) begin
      r_s1_valid  <= i_valid;
      r_s1_sign   <= i_multiplicand[N-1] ^ i_multiplier[N-1];
      r_s1_a      <= i_multiplicand[N-2:0];
      r_s1_b      <= i_multiplier[N-2:0];
      r_s2_valid  <= r_s1_valid;
      r_s2_sign   <= r_s1_sign;
      r_s2_prod   <= {{(N-1){1'b0}}, r_s1_a} * {{(N-1){1'b0}}, r_s1_b};
      r_s3_valid  <= r_s2_valid;
      r_s3_result <= {w_sign, w_mag};
      r_s3_ovr    <= w_ovr;
    end
  end

  // Set has priority over clear when both happen in the same cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sticky <= 1'b0;
    end else if (r_s3_valid && i_ready && r_s3_ovr) begin
      r_sticky <= 1'b1;
    end else if (i_clr_ovr) begin
      r_sticky <= 1'b0;
    end
  end

  assign o_valid      = r_s3_valid;
  assign o_result     = r_s3_result;
  assign o_ovr        = r_s3_ovr;
  assign o_ovr_sticky = r_sticky;

endmodule

`default_nettype wire

// File: tb/tb_fixed_multiplier_pipe.sv
// ----------------------------------------------------------------------------
// tb_fixed_multiplier_pipe : directed bench, three parameter variants in parallel
// Rev 1.0 - initial release
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_fixed_multiplier_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_ready;
  logic        clr_ovr;

  logic        rdy_d, rdy_w, rdy_t;
  logic        vld_d, vld_w, vld_t;
  logic [15:0] res_d, res_w, res_t;
  logic        ovr_d, ovr_w, ovr_t;
  logic        stk_d, stk_w, stk_t;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Rounding + saturation
  fixed_multiplier_pipe #(.N(16), .Q(12), .ROUND(1), .SAT(1)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_valid(in_valid), .o_ready(rdy_d),
    .i_multiplicand(a), .i_multiplier(b), .o_valid(vld_d), .i_ready(out_ready),
    .o_result(res_d), .o_ovr(ovr_d), .i_clr_ovr(clr_ovr), .o_ovr_sticky(stk_d));

  // Rounding + wrap
  fixed_multiplier_pipe #(.N(16), .Q(12), .ROUND(1), .SAT(0)) u_wrap (
    .i_clk(clk), .i_rst(rst), .i_valid(in_valid), .o_ready(rdy_w),
    .i_multiplicand(a), .i_multiplier(b), .o_valid(vld_w), .i_ready(out_ready),
    .o_result(res_w), .o_ovr(ovr_w), .i_clr_ovr(clr_ovr), .o_ovr_sticky(stk_w));

  // Truncation + saturation
  fixed_multiplier_pipe #(.N(16), .Q(12), .ROUND(0), .SAT(1)) u_trunc (
    .i_clk(clk), .i_rst(rst), .i_valid(in_valid), .o_ready(rdy_t),
    .i_multiplicand(a), .i_multiplier(b), .o_valid(vld_t), .i_ready(out_ready),
    .o_result(res_t), .o_ovr(ovr_t), .i_clr_ovr(clr_ovr), .o_ovr_sticky(stk_t));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one operand pair into an idle pipe and wait for its result.
  task automatic run_one(input logic [15:0] ia, input logic [15:0] ib,
                         output logic [15:0] rd, output logic [15:0] rw,
                         output logic [15:0] rt, output logic od,
                         output logic ow, output logic ot, output int lat);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a         = ia;
    b         = ib;
    tick();
    in_valid  = 1'b0;
    lat       = 1;
    while (!vld_d && lat < 10) begin
      tick();
      lat++;
    end
    rd = res_d; rw = res_w; rt = res_t;
    od = ovr_d; ow = ovr_w; ot = ovr_t;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b0; clr_ovr = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (rdy_d !== 1'b1) begin n_err++; $display("FAIL reset_o_ready: got %b want 1", rdy_d); end
    n_cmp++;
    if (vld_d !== 1'b0) begin n_err++; $display("FAIL reset_o_valid: got %b want 0", vld_d); end
    n_cmp++;
    if (res_d !== 16'h0000) begin n_err++; $display("FAIL reset_o_result: got %h want 0000", res_d); end
    n_cmp++;
    if (ovr_d !== 1'b0 || stk_d !== 1'b0) begin
      n_err++; $display("FAIL reset_flags: got ovr=%b sticky=%b want 0/0", ovr_d, stk_d);
    end
    rst = 1'b0;
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [15:0] rd, rw, rt;
    logic od, ow, ot;
    int lat;
    run_one(16'h1800, 16'h2000, rd, rw, rt, od, ow, ot, lat);
    n_cmp++;
    if (lat !== 3) begin n_err++; $display("FAIL basic_latency: got %0d want 3", lat); end
    n_cmp++;
    if (rd !== 16'h3000 || od !== 1'b0) begin
      n_err++; $display("FAIL basic_pos: got %h ovr=%b want 3000 ovr=0", rd, od);
    end
    n_cmp++;
    if (rt !== 16'h3000) begin n_err++; $display("FAIL basic_pos_trunc: got %h want 3000", rt); end
    tick();
    run_one(16'h9800, 16'h2000, rd, rw, rt, od, ow, ot, lat);
    n_cmp++;
    if (rd !== 16'hB000 || od !== 1'b0) begin
      n_err++; $display("FAIL basic_neg: got %h ovr=%b want b000 ovr=0", rd, od);
    end
    tick();
    run_one(16'h1000, 16'hB000, rd, rw, rt, od, ow, ot, lat);
    n_cmp++;
    if (rd !== 16'hB000) begin n_err++; $display("FAIL basic_unit: got %h want b000", rd); end
    tick();
    n_cmp++;
    if (stk_d !== 1'b0) begin n_err++; $display("FAIL basic_sticky: got %b want 0", stk_d); end
  endtask

  task automatic test_overflow();
    logic [15:0] rd, rw, rt;
    logic od, ow, ot;
    int lat;
    run_one(16'h4000, 16'h4000, rd, rw, rt, od, ow, ot, lat);
    n_cmp++;
    if (rd !== 16'h7FFF || od !== 1'b1) begin
      n_err++; $display("FAIL ovr_sat: got %h ovr=%b want 7fff ovr=1", rd, od);
    end
    n_cmp++;
    if (rw !== 16'h0000 || ow !== 1'b1) begin
      n_err++; $display("FAIL ovr_wrap: got %h ovr=%b want 0000 ovr=1", rw, ow);
    end
    n_cmp++;
    if (stk_d !== 1'b0) begin n_err++; $display("FAIL ovr_sticky_early: got %b want 0", stk_d); end
    tick();
    n_cmp++;
    if (stk_d !== 1'b1) begin n_err++; $display("FAIL ovr_sticky: got %b want 1", stk_d); end
  endtask

  task automatic test_rounding();
    logic [15:0] rd, rw, rt;
    logic od, ow, ot;
    int lat;
    run_one(16'h0001, 16'h0800, rd, rw, rt, od, ow, ot, lat);
    n_cmp++;
    if (rd !== 16'h0001) begin n_err++; $display("FAIL round_up: got %h want 0001", rd); end
    n_cmp++;
    if (rt !== 16'h0000) begin n_err++; $display("FAIL round_trunc: got %h want 0000", rt); end
    tick();
    run_one(16'h8001, 16'h0800, rd, rw, rt, od, ow, ot, lat);
    n_cmp++;
    if (rd !== 16'h8001) begin n_err++; $display("FAIL round_neg: got %h want 8001", rd); end
    n_cmp++;
    if (rt !== 16'h0000) begin n_err++; $display("FAIL round_negzero: got %h want 0000", rt); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [15:0] opa [6] = '{16'h1000, 16'h9000, 16'h1000, 16'h9000, 16'h1000, 16'h9000};
    logic [15:0] opb [6] = '{16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0500, 16'h0600};
    logic [15:0] expv[6] = '{16'h0100, 16'h8200, 16'h0300, 16'h8400, 16'h0500, 16'h8600};
    int sent = 0;
    int got  = 0;
    logic stalled_prev = 1'b0;
    logic [15:0] held = '0;
    for (int c = 0; c < 40 && got < 6; c++) begin
      out_ready = !(c >= 4 && c <= 7);
      if (sent < 6) begin
        in_valid = 1'b1; a = opa[sent]; b = opb[sent];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (stalled_prev) begin
        n_cmp++;
        if (res_d !== held) begin n_err++; $display("FAIL bp_hold: got %h want %h", res_d, held); end
      end
      if (vld_d && !out_ready) begin
        n_cmp++;
        if (rdy_d !== 1'b0) begin n_err++; $display("FAIL bp_o_ready: got %b want 0", rdy_d); end
        held = res_d;
        stalled_prev = 1'b1;
      end else begin
        stalled_prev = 1'b0;
      end
      if (vld_d && out_ready) begin
        n_cmp++;
        if (res_d !== expv[got]) begin
          n_err++; $display("FAIL bp_order[%0d]: got %h want %h", got, res_d, expv[got]);
        end
        got++;
      end
      if (in_valid && rdy_d) sent++;
      tick();
    end
    n_cmp++;
    if (got !== 6) begin n_err++; $display("FAIL bp_count: got %0d results want 6", got); end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (vld_d !== 1'b0) begin n_err++; $display("FAIL bp_extra: got o_valid=%b want 0", vld_d); end
      tick();
    end
  endtask

  task automatic test_sticky_clear();
    int n = 0;
    clr_ovr = 1'b1;
    tick();
    clr_ovr = 1'b0;
    n_cmp++;
    if (stk_d !== 1'b0) begin n_err++; $display("FAIL stk_preclear: got %b want 0", stk_d); end
    out_ready = 1'b0;
    in_valid  = 1'b1; a = 16'h4000; b = 16'h4000;
    tick();
    in_valid  = 1'b0;
    while (!vld_d && n < 10) begin tick(); n++; end
    tick();
    n_cmp++;
    if (vld_d !== 1'b1 || ovr_d !== 1'b1 || stk_d !== 1'b0) begin
      n_err++; $display("FAIL stk_pending: got vld=%b ovr=%b sticky=%b want 1/1/0", vld_d, ovr_d, stk_d);
    end
    out_ready = 1'b1;
    clr_ovr   = 1'b1;
    tick();
    n_cmp++;
    if (stk_d !== 1'b1) begin n_err++; $display("FAIL stk_set_wins: got %b want 1", stk_d); end
    tick();
    clr_ovr = 1'b0;
    n_cmp++;
    if (stk_d !== 1'b0) begin n_err++; $display("FAIL stk_clear: got %b want 0", stk_d); end
  endtask

  task automatic test_reset_midstream();
    logic [15:0] rd, rw, rt;
    logic od, ow, ot;
    int lat;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a = 16'h1800; b = 16'h2000; tick();
    a = 16'h4000; b = 16'h4000; tick();
    a = 16'h9800; b = 16'h2000; tick();
    in_valid = 1'b0;
    rst      = 1'b1;
    tick();
    n_cmp++;
    if (vld_d !== 1'b0 || res_d !== 16'h0000) begin
      n_err++; $display("FAIL rst_mid: got vld=%b res=%h want 0/0000", vld_d, res_d);
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (vld_d !== 1'b0) begin n_err++; $display("FAIL rst_ghost: got o_valid=%b want 0", vld_d); end
      tick();
    end
    run_one(16'h9800, 16'h2000, rd, rw, rt, od, ow, ot, lat);
    n_cmp++;
    if (lat !== 3 || rd !== 16'hB000) begin
      n_err++; $display("FAIL rst_after: got %h lat=%0d want b000 lat=3", rd, lat);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_rounding();
    test_back_to_back();
    test_sticky_clear();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

`default_nettype wire
